// File: rtl/bert_pattern_gen.sv
// PRBS7/PRBS15 transmit pattern generator with programmable periodic error injection.
// Emits the corrupted byte and its clean reference over a valid/ready stream.
module bert_pattern_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        mode,
    input  logic [15:0] burst_len,
    input  logic [7:0]  inj_period,
    input  logic [7:0]  inj_mask,
    output logic [7:0]  tx_data,
    output logic [7:0]  tx_ref,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] byte_count,
    output logic [15:0] inj_count
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LFSR_W  = 15;
    localparam int unsigned STEP_W  = LFSR_W + DATA_W;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned BCNT_W  = 32;
    localparam int unsigned ICNT_W  = 16;
    localparam logic [LFSR_W-1:0] SEED = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic [LFSR_W-1:0] lfsr;
    logic              mode_q;
    logic [LEN_W-1:0]  burst_q;
    logic [DATA_W-1:0] period_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] inj_cnt;
    logic              corrupt;

    logic [STEP_W-1:0] seed_step;
    logic [STEP_W-1:0] run_step;
    logic [DATA_W-1:0] inj_cnt_d;
    logic              corrupt_d;
    logic              start_corrupt;
    logic              hs;
    logic              start_go;
    logic              inj_en;
    logic              last_beat;

    // Eight LFSR steps; returns {next state, byte} with the first bit in the MSB.
    // For PRBS7 only the low 7 state bits are live; the rest are forced to zero.
    function automatic logic [STEP_W-1:0] prbs_byte(input logic m, input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] st;
        logic [DATA_W-1:0] b;
        logic              fb;
        st = s;
        b  = '0;
        for (int i = 0; i < 8; i++) begin
            fb = m ? (st[14] ^ st[13]) : (st[6] ^ st[5]);
            st = {st[13:0], fb};
            b  = {b[6:0], fb};
        end
        if (!m) st = {8'd0, st[6:0]};
        return {st, b};
    endfunction

    assign hs            = tx_valid & tx_ready;
    assign start_go      = (state == IDLE) && start && !stop;
    assign inj_en        = (period_q != 8'd0) && (mask_q != 8'd0);
    assign start_corrupt = (inj_period == 8'd1) && (inj_mask != 8'd0);
    assign last_beat     = (burst_q != 16'd0) && ((byte_count + 32'd1) == {16'd0, burst_q});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic; stop outranks burst completion.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start && !stop) state_d = RUN;
            RUN: begin
                if (stop)                   state_d = IDLE;
                else if (hs && last_beat)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next pattern bytes and injection counter for the beat after a handshake.
    always_comb begin
        seed_step = prbs_byte(mode, SEED);
        run_step  = prbs_byte(mode_q, lfsr);
        inj_cnt_d = inj_cnt;
        if (corrupt)     inj_cnt_d = period_q;
        else if (inj_en) inj_cnt_d = inj_cnt - 8'd1;
        corrupt_d = inj_en && (inj_cnt_d == 8'd1);
    end

    // Datapath: lfsr holds the state after the byte currently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED;
            mode_q     <= 1'b0;
            burst_q    <= '0;
            period_q   <= '0;
            mask_q     <= '0;
            inj_cnt    <= '0;
            corrupt    <= 1'b0;
            tx_data    <= '0;
            tx_ref     <= '0;
            byte_count <= '0;
            inj_count  <= '0;
        end else if (start_go) begin
            mode_q     <= mode;
            burst_q    <= burst_len;
            period_q   <= inj_period;
            mask_q     <= inj_mask;
            inj_cnt    <= inj_period;
            corrupt    <= start_corrupt;
            lfsr       <= seed_step[STEP_W-1:DATA_W];
            tx_ref     <= seed_step[DATA_W-1:0];
            tx_data    <= seed_step[DATA_W-1:0] ^ (start_corrupt ? inj_mask : 8'd0);
            byte_count <= '0;
            inj_count  <= '0;
        end else if ((state == RUN) && hs) begin
            lfsr       <= run_step[STEP_W-1:DATA_W];
            tx_ref     <= run_step[DATA_W-1:0];
            tx_data    <= run_step[DATA_W-1:0] ^ (corrupt_d ? mask_q : 8'd0);
            inj_cnt    <= inj_cnt_d;
            corrupt    <= corrupt_d;
            byte_count <= byte_count + BCNT_W'(1);
            if (corrupt && (inj_count != 16'hFFFF)) inj_count <= inj_count + ICNT_W'(1);
        end
    end

    // Registered status outputs track the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_valid <= (state_d == RUN);
            busy     <= (state_d == RUN);
            done     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_bert_pattern_gen.sv
// Self-checking bench for bert_pattern_gen: bit-recurrence PRBS model plus
// modulo-arithmetic injection model, with directed and randomized runs.
module tb_bert_pattern_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop, mode, tx_ready;
    logic [15:0] burst_len;
    logic [7:0]  inj_period, inj_mask;
    logic [7:0]  tx_data, tx_ref;
    logic        tx_valid, busy, done;
    logic [31:0] byte_count;
    logic [15:0] inj_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref7  [0:399];
    logic [7:0] ref15 [0:399];

    logic [7:0] got_data[$];
    logic [7:0] got_ref[$];
    int done_end, busy_end, done_after, valid_after, first_valid, hold_errs, timed_out, run_cycles;

    bert_pattern_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .inj_period(inj_period), .inj_mask(inj_mask),
        .tx_data(tx_data), .tx_ref(tx_ref), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .byte_count(byte_count), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output bit n = bit(n-N) xor bit(n-N+1), history seeded with N ones.
    task automatic init_model();
        bit q[$];
        int nn;
        logic [7:0] b;
        for (int sel = 0; sel < 2; sel++) begin
            nn = (sel == 1) ? 15 : 7;
            q.delete();
            for (int i = 0; i < nn; i++) q.push_back(1'b1);
            for (int j = 0; j < 3200; j++) q.push_back(q[j] ^ q[j+1]);
            for (int k = 0; k < 400; k++) begin
                b = 8'd0;
                for (int t = 0; t < 8; t++) b = {b[6:0], q[nn + 8*k + t]};
                if (sel == 1) ref15[k] = b;
                else          ref7[k]  = b;
            end
        end
    endtask

    function automatic logic [7:0] model_ref(input bit m, input int k);
        return m ? ref15[k] : ref7[k];
    endfunction

    function automatic bit model_hit(input int k, input logic [7:0] p, input logic [7:0] msk);
        if (p == 8'd0 || msk == 8'd0) return 1'b0;
        return ((k + 1) % int'(p)) == 0;
    endfunction

    // Drives one run and records accepted beats; rmode 0=always ready, 1=1,0,0,1 pattern, 2=random.
    task automatic run_burst(input bit m, input logic [15:0] bl, input logic [7:0] ip,
                             input logic [7:0] im, input int stop_after, input int rmode,
                             input bit poke_start);
        int hs, cyc;
        bit pend, ended;
        logic [7:0] pd, pr;
        got_data.delete();
        got_ref.delete();
        done_end = 0; busy_end = 0; done_after = 0; valid_after = 0;
        hold_errs = 0; timed_out = 0;
        mode = m; burst_len = bl; inj_period = ip; inj_mask = im;
        start = 1'b1; stop = 1'b0; tx_ready = 1'b0;
        tick();
        start = 1'b0;
        mode = 1'($urandom); burst_len = 16'($urandom); inj_period = 8'($urandom); inj_mask = 8'($urandom);
        first_valid = int'(tx_valid);
        hs = 0; cyc = 0; pend = 0; ended = 0; pd = '0; pr = '0;
        while (!ended && cyc < 4000) begin
            if (!tx_valid) begin
                ended = 1;
                done_end = int'(done);
                busy_end = int'(busy);
            end else begin
                if (pend && (tx_data !== pd || tx_ref !== pr)) hold_errs++;
                case (rmode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: tx_ready = 1'($urandom_range(0, 1));
                endcase
                if (tx_ready) begin
                    got_data.push_back(tx_data);
                    got_ref.push_back(tx_ref);
                    hs++;
                    pend = 0;
                    if (stop_after != 0 && hs == stop_after) stop = 1'b1;
                end else begin
                    pend = 1;
                    pd = tx_data;
                    pr = tx_ref;
                end
                tick();
                stop = 1'b0;
                cyc++;
            end
        end
        run_cycles = cyc;
        if (!ended) timed_out = 1;
        tx_ready = 1'b0;
        if (poke_start) start = 1'b1;
        tick();
        start = 1'b0;
        done_after  = int'(done);
        valid_after = int'(tx_valid);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; tx_ready = 1'b0;
        burst_len = '0; inj_period = '0; inj_mask = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({tx_data, tx_ref, tx_valid, busy, done, byte_count, inj_count} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got data=%h ref=%h v=%b busy=%b done=%b bc=%0d ic=%0d exp all zero",
                     tx_data, tx_ref, tx_valid, busy, done, byte_count, inj_count);
        end
    endtask

    task automatic test_prbs7_burst();
        run_burst(1'b0, 16'd4, 8'd0, 8'd0, 0, 0, 1'b1);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL prbs7_timeout got %0d exp 0", timed_out); end
        checks++;
        if (first_valid !== 1) begin errors++; $display("FAIL prbs7_latency got valid=%0d exp 1", first_valid); end
        checks++;
        if (got_ref.size() !== 4) begin errors++; $display("FAIL prbs7_beats got %0d exp 4", got_ref.size()); end
        else begin
            checks++;
            if (got_ref[0] !== 8'h02 || got_ref[1] !== 8'h0C) begin
                errors++; $display("FAIL prbs7_first_bytes got %h %h exp 02 0c", got_ref[0], got_ref[1]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_data[k] !== ref7[k] || got_ref[k] !== ref7[k]) begin
                    errors++; $display("FAIL prbs7_byte%0d got %h/%h exp %h", k, got_data[k], got_ref[k], ref7[k]);
                end
            end
        end
        checks++;
        if (run_cycles !== 4) begin errors++; $display("FAIL prbs7_throughput got %0d cycles exp 4", run_cycles); end
        checks++;
        if (done_end !== 1 || busy_end !== 0) begin
            errors++; $display("FAIL prbs7_done got done=%0d busy=%0d exp 1 0", done_end, busy_end);
        end
        checks++;
        if (done_after !== 0 || valid_after !== 0) begin
            errors++; $display("FAIL start_in_done got done=%0d valid=%0d exp 0 0", done_after, valid_after);
        end
        checks++;
        if (byte_count !== 32'd4 || inj_count !== 16'd0) begin
            errors++; $display("FAIL prbs7_counts got bc=%0d ic=%0d exp 4 0", byte_count, inj_count);
        end
    endtask

    task automatic test_prbs7_period();
        int bad;
        run_burst(1'b0, 16'd128, 8'd0, 8'd0, 0, 0, 1'b0);
        checks++;
        if (got_ref.size() !== 128) begin errors++; $display("FAIL period_beats got %0d exp 128", got_ref.size()); end
        else begin
            checks++;
            if (got_ref[127] !== 8'h02) begin errors++; $display("FAIL period_byte127 got %h exp 02", got_ref[127]); end
            bad = 0;
            for (int k = 0; k < 128; k++)
                if (got_data[k] !== ref7[k] || got_ref[k] !== ref7[k]) bad++;
            checks++;
            if (bad !== 0) begin errors++; $display("FAIL period_stream got %0d bad beats exp 0", bad); end
        end
    endtask

    task automatic test_prbs15();
        run_burst(1'b1, 16'd2, 8'd0, 8'd0, 0, 0, 1'b0);
        checks++;
        if (got_ref.size() !== 2) begin errors++; $display("FAIL prbs15_beats got %0d exp 2", got_ref.size()); end
        else begin
            checks++;
            if (got_ref[0] !== 8'h00 || got_ref[1] !== 8'h02 || got_data[0] !== ref15[0] || got_data[1] !== ref15[1]) begin
                errors++; $display("FAIL prbs15_bytes got %h %h exp 00 02", got_ref[0], got_ref[1]);
            end
        end
        checks++;
        if (done_end !== 1) begin errors++; $display("FAIL prbs15_done got %0d exp 1", done_end); end
    endtask

    task automatic test_injection();
        logic [7:0] exp;
        run_burst(1'b0, 16'd9, 8'd3, 8'h01, 0, 0, 1'b0);
        checks++;
        if (got_data.size() !== 9) begin errors++; $display("FAIL inj_beats got %0d exp 9", got_data.size()); end
        else begin
            for (int k = 0; k < 9; k++) begin
                exp = ref7[k] ^ ((k % 3 == 2) ? 8'h01 : 8'h00);
                checks++;
                if (got_data[k] !== exp || got_ref[k] !== ref7[k]) begin
                    errors++; $display("FAIL inj_byte%0d got %h/%h exp %h/%h", k, got_data[k], got_ref[k], exp, ref7[k]);
                end
            end
        end
        checks++;
        if (inj_count !== 16'd3) begin errors++; $display("FAIL inj_count got %0d exp 3", inj_count); end
        run_burst(1'b1, 16'd5, 8'd1, 8'h80, 0, 0, 1'b0);
        for (int k = 0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== (ref15[k] ^ 8'h80)) begin
                errors++; $display("FAIL inj_every_byte%0d got %h exp %h", k, got_data[k], ref15[k] ^ 8'h80);
            end
        end
        checks++;
        if (inj_count !== 16'd5 || byte_count !== 32'd5) begin
            errors++; $display("FAIL inj_every_counts got ic=%0d bc=%0d exp 5 5", inj_count, byte_count);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        run_burst(1'b0, 16'd10, 8'd4, 8'h5A, 0, 1, 1'b0);
        checks++;
        if (hold_errs !== 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", hold_errs); end
        bad = 0;
        for (int k = 0; k < got_data.size(); k++)
            if (got_ref[k] !== ref7[k] || got_data[k] !== (ref7[k] ^ (model_hit(k, 8'd4, 8'h5A) ? 8'h5A : 8'h00))) bad++;
        checks++;
        if (bad !== 0 || got_data.size() !== 10) begin
            errors++; $display("FAIL bp_stream got %0d beats %0d bad exp 10 0", got_data.size(), bad);
        end
        checks++;
        if (byte_count !== 32'd10 || run_cycles <= 10) begin
            errors++; $display("FAIL bp_count got bc=%0d cycles=%0d exp 10 >10", byte_count, run_cycles);
        end
    endtask

    task automatic test_stop();
        run_burst(1'b0, 16'd0, 8'd0, 8'd0, 5, 0, 1'b0);
        checks++;
        if (got_data.size() !== 5 || byte_count !== 32'd5) begin
            errors++; $display("FAIL stop_count got beats=%0d bc=%0d exp 5 5", got_data.size(), byte_count);
        end
        checks++;
        if (done_end !== 0 || done_after !== 0 || busy_end !== 0) begin
            errors++; $display("FAIL stop_no_done got done=%0d/%0d busy=%0d exp 0", done_end, done_after, busy_end);
        end
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL stop_timeout got %0d exp 0", timed_out); end
    endtask

    task automatic test_start_stop_both();
        mode = 1'b0; burst_len = 16'd3; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_stop_both got valid=%b busy=%b exp 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_reset_midrun();
        mode = 1'b0; burst_len = 16'd0; inj_period = 8'd1; inj_mask = 8'hFF;
        tx_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (byte_count !== 32'd3 || tx_valid !== 1'b1) begin
            errors++; $display("FAIL midrun_progress got bc=%0d valid=%b exp 3 1", byte_count, tx_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({tx_data, tx_ref, tx_valid, busy, done, byte_count, inj_count} !== 67'd0) begin
            errors++; $display("FAIL midrun_reset got data=%h ref=%h v=%b busy=%b done=%b bc=%0d ic=%0d exp all zero",
                               tx_data, tx_ref, tx_valid, busy, done, byte_count, inj_count);
        end
        rst = 1'b0; tx_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit m;
        logic [15:0] bl;
        logic [7:0] ip, im, exp;
        int bad, hits;
        for (int it = 0; it < 8; it++) begin
            m  = 1'($urandom);
            bl = 16'($urandom_range(1, 60));
            ip = 8'($urandom_range(0, 5));
            im = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_burst(m, bl, ip, im, 0, 2, 1'b0);
            bad = 0; hits = 0;
            for (int k = 0; k < got_data.size(); k++) begin
                exp = model_ref(m, k);
                if (model_hit(k, ip, im)) begin exp = exp ^ im; hits++; end
                if (got_data[k] !== exp || got_ref[k] !== model_ref(m, k)) bad++;
            end
            checks++;
            if (bad !== 0 || got_data.size() !== int'(bl) || hold_errs !== 0) begin
                errors++; $display("FAIL rand%0d_stream got beats=%0d bad=%0d holds=%0d exp %0d 0 0",
                                   it, got_data.size(), bad, hold_errs, bl);
            end
            checks++;
            if (byte_count !== 32'(bl) || inj_count !== 16'(hits) || done_end !== 1) begin
                errors++; $display("FAIL rand%0d_counts got bc=%0d ic=%0d done=%0d exp %0d %0d 1",
                                   it, byte_count, inj_count, done_end, bl, hits);
            end
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_prbs7_burst();
        test_prbs7_period();
        test_prbs15();
        test_injection();
        test_backpressure();
        test_stop();
        test_start_stop_both();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
